// File: rtl/mips_mem_responder.sv
// Word-addressed instruction/data store for the multicycle mips core, with a preload port and
// core reset sequencing. Define MEM_RESP_MMIO_EN to enable the output register at MMIO_ADDR.
module mips_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_ADDR  = 32'hFFFF_FFFC
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [31:0] INST_ADDR,
  output logic [31:0] INST,
  input  logic [31:0] DATA_ADDR,
  input  logic [31:0] DATA_OUT,
  input  logic        DATA_WRITE,
  output logic [31:0] DATA_IN,
  input  logic        LOAD_VALID,
  input  logic [31:0] LOAD_ADDR,
  input  logic [31:0] LOAD_DATA,
  output logic        LOAD_READY,
  input  logic        LOAD_DONE,
  output logic        CPU_NRST,
  output logic        ERR,
  output logic [31:0] CYCLE_COUNT,
  output logic [31:0] MMIO_OUT,
  output logic        MMIO_STROBE
);

`ifdef MEM_RESP_MMIO_EN
  localparam bit MmioEn = 1'b1;
`else
  localparam bit MmioEn = 1'b0;
`endif
  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StLoad, StRelease, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [Words];
  logic        cpu_nrst_q;
  logic        err_q;
  logic [31:0] cycle_q;
  logic [31:0] mmio_rd;

  logic                  we;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           wdata;
  logic                  mmio_we;
  logic                  err_set;

  function automatic logic is_mmio(input logic [31:0] addr);
    return MmioEn && (addr == MMIO_ADDR);
  endfunction

  function automatic logic is_oor(input logic [31:0] addr);
    return (|addr[31:ADDR_WIDTH+2]) && !is_mmio(addr);
  endfunction

  // Asynchronous reads; low address bits are ignored.
  always_comb begin
    INST = '0;
    if (is_mmio(INST_ADDR)) begin
      INST = mmio_rd;
    end else if (!is_oor(INST_ADDR)) begin
      INST = mem_q[INST_ADDR[ADDR_WIDTH+1:2]];
    end
  end

  always_comb begin
    DATA_IN = '0;
    if (is_mmio(DATA_ADDR)) begin
      DATA_IN = mmio_rd;
    end else if (!is_oor(DATA_ADDR)) begin
      DATA_IN = mem_q[DATA_ADDR[ADDR_WIDTH+1:2]];
    end
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    mmio_we = 1'b0;
    err_set = 1'b0;
    widx    = (state_q == StLoad) ? LOAD_ADDR[ADDR_WIDTH+1:2] : DATA_ADDR[ADDR_WIDTH+1:2];
    wdata   = (state_q == StLoad) ? LOAD_DATA : DATA_OUT;
    unique case (state_q)
      StLoad: begin
        // The output register is not a preload target; such a word is dropped as an error.
        if (LOAD_VALID) begin
          we      = !is_oor(LOAD_ADDR) && !is_mmio(LOAD_ADDR);
          err_set = is_oor(LOAD_ADDR) || is_mmio(LOAD_ADDR) || (|LOAD_ADDR[1:0]);
        end
        if (LOAD_DONE) state_d = StRelease;
      end
      StRelease: state_d = StRun;
      StRun: begin
        if (DATA_WRITE) begin
          mmio_we = is_mmio(DATA_ADDR);
          we      = !is_oor(DATA_ADDR) && !is_mmio(DATA_ADDR);
          err_set = is_oor(DATA_ADDR) || (|DATA_ADDR[1:0]);
        end
        if (|INST_ADDR[1:0]) err_set = 1'b1;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q    <= StLoad;
      cpu_nrst_q <= 1'b0;
      err_q      <= 1'b0;
      cycle_q    <= '0;
    end else begin
      state_q    <= state_d;
      cpu_nrst_q <= (state_d == StRun);
      if (err_set) err_q <= 1'b1;
      if (state_q == StRun) cycle_q <= cycle_q + 32'd1;
    end
  end

  // Memory has no reset so preloaded contents survive a reset.
  always_ff @(posedge CLK) begin
    if (NRST && we) mem_q[widx] <= wdata;
  end

`ifdef MEM_RESP_MMIO_EN
  logic [31:0] mmio_out_q;
  logic        mmio_strobe_q;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      mmio_out_q    <= '0;
      mmio_strobe_q <= 1'b0;
    end else begin
      mmio_strobe_q <= mmio_we;
      if (mmio_we) mmio_out_q <= DATA_OUT;
    end
  end

  assign mmio_rd     = mmio_out_q;
  assign MMIO_OUT    = mmio_out_q;
  assign MMIO_STROBE = mmio_strobe_q;
`else
  logic unused_mmio;
  assign unused_mmio = mmio_we;
  assign mmio_rd     = '0;
  assign MMIO_OUT    = '0;
  assign MMIO_STROBE = 1'b0;
`endif

  assign LOAD_READY  = (state_q == StLoad);
  assign CPU_NRST    = cpu_nrst_q;
  assign ERR         = err_q;
  assign CYCLE_COUNT = cycle_q;

endmodule
